// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg: shared configuration helpers for the pipelined adder/subtractor.
// Provides the default operand width/stage count, the per-stage chunk width, and a
// legality check that the operand width divides evenly into the stages.
package pipe_adder_pkg;
    localparam int DEFAULT_WIDTH  = 16;
    localparam int DEFAULT_STAGES = 4;

    function automatic int chunk_w(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic bit width_ok(input int width, input int stages);
        return stages > 0 && width % stages == 0;
    endfunction
endpackage

// File: rtl/adder_chunk.sv
// adder_chunk: combinational N-bit ripple-carry adder made of full-adder cells.
// Ports: a, b (N-bit addends), cin (carry in), sum (N-bit result),
//        cout (carry out of the top bit), c_msb_in (carry into the top bit).
module adder_chunk #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         c_msb_in
);
    logic c;

    always_comb begin
        c        = cin;
        c_msb_in = cin;
        sum      = '0;
        for (int i = 0; i < N; i++) begin
            if (i == N - 1)
                c_msb_in = c;
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end
endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: pipelined WIDTH-bit adder/subtractor, one CHUNK-bit slice per stage,
// LSB chunk first, with a registered carry between stages and valid/ready on both ends.
// Ports: clk, rst (async, active-high); in_valid/in_ready, a, b, cin, sub (input beat);
//        out_valid/out_ready, sum, cout (result beat).
// Optional: define PIPE_ADDER_OVF_EN to add output ovf (signed overflow of the result).
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPE_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CHUNK = chunk_w(WIDTH, STAGES);

    if (!width_ok(WIDTH, STAGES)) begin : g_bad_cfg
        $error("pipe_adder: WIDTH must be a multiple of STAGES");
    end

    // w_in[k]: word entering stage k; low k chunks are finished sum, the rest is operand a.
    logic [WIDTH-1:0] w_in [STAGES+1];
    logic             c_in [STAGES+1];
    logic [STAGES:0]  vin;
    logic [STAGES:0]  ld;

    assign w_in[0] = a;
    assign c_in[0] = sub | cin;
    assign vin[0]  = in_valid;

    // A stage may load when it is empty or its content moves on this cycle.
    always_comb begin
        ld[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--)
            ld[k] = !vin[k+1] | ld[k+1];
    end

    assign in_ready  = ld[0];
    assign out_valid = vin[STAGES];
    assign sum       = w_in[STAGES];
    assign cout      = c_in[STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        // Only the not-yet-consumed chunks of effective b travel with the stage.
        logic [WIDTH-k*CHUNK-1:0] b_here;
        logic [CHUNK-1:0]         s_c;
        logic                     co;
        logic                     c_msb;
        logic                     unused_msb;
        logic [WIDTH-1:0]         w_nxt;
        logic [WIDTH-1:0]         w_q;
        logic                     v_q;
        logic                     c_q;

        if (k == 0) begin : g_first
            assign b_here = b ^ {WIDTH{sub}};
        end else begin : g_rest
            assign b_here = g_st[k-1].g_fwd.b_q;
        end

        assign unused_msb = c_msb;

        adder_chunk #(.N(CHUNK)) u_chunk (
            .a        (w_in[k][k*CHUNK +: CHUNK]),
            .b        (b_here[CHUNK-1:0]),
            .cin      (c_in[k]),
            .sum      (s_c),
            .cout     (co),
            .c_msb_in (c_msb)
        );

        always_comb begin
            w_nxt                    = w_in[k];
            w_nxt[k*CHUNK +: CHUNK]  = s_c;
        end

        always_ff @(posedge clk or posedge rst)
            if (rst) begin
                v_q <= 1'b0;
                w_q <= '0;
                c_q <= 1'b0;
            end else if (ld[k]) begin
                v_q <= vin[k];
                w_q <= w_nxt;
                c_q <= co;
            end

        assign vin[k+1]  = v_q;
        assign w_in[k+1] = w_q;
        assign c_in[k+1] = c_q;

        if (k < STAGES - 1) begin : g_fwd
            logic [WIDTH-(k+1)*CHUNK-1:0] b_q;
            always_ff @(posedge clk or posedge rst)
                if (rst)
                    b_q <= '0;
                else if (ld[k])
                    b_q <= b_here[WIDTH-k*CHUNK-1:CHUNK];
        end

`ifdef PIPE_ADDER_OVF_EN
        // Signed overflow: carry into the MSB differs from carry out of it.
        if (k == STAGES - 1) begin : g_ovf
            always_ff @(posedge clk or posedge rst)
                if (rst)
                    ovf <= 1'b0;
                else if (ld[k])
                    ovf <= c_msb ^ co;
        end
`endif
    end
endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: scoreboard bench for pipe_adder (16-bit/4-stage and 8-bit/1-stage).
module tb_pipe_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic [15:0] a = '0, b = '0, sum;
    logic        cin = 1'b0, sub = 1'b0, cout;
    logic        ovf;

    logic        in_valid8 = 1'b0, in_ready8, out_valid8;
    logic [7:0]  a8 = '0, b8 = '0, sum8;
    logic        cin8 = 1'b0, sub8 = 1'b0, cout8;
    logic        ovf8;

    pipe_adder #(.WIDTH(16), .STAGES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef PIPE_ADDER_OVF_EN
        , .ovf(ovf)
`endif
    );

    pipe_adder #(.WIDTH(8), .STAGES(1)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .out_valid(out_valid8), .out_ready(1'b1), .sum(sum8), .cout(cout8)
`ifdef PIPE_ADDER_OVF_EN
        , .ovf(ovf8)
`endif
    );

`ifndef PIPE_ADDER_OVF_EN
    assign ovf  = 1'b0;
    assign ovf8 = 1'b0;
`endif

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          checks = 0, errors = 0, cyc = 0, now = 0;
    bit          ix, ox, ir, ov;
    logic [15:0] got_s;
    logic        got_c, got_o;

    function automatic exp_t model(input logic [15:0] aa, input logic [15:0] bb,
                                   input logic ci, input logic sb, input int t);
        exp_t        e;
        logic [15:0] be;
        logic [16:0] f;
        be    = sb ? ~bb : bb;
        f     = {1'b0, aa} + {1'b0, be} + {16'd0, sb ? 1'b1 : ci};
        e.s   = f[15:0];
        e.c   = f[16];
        e.o   = (aa[15] == be[15]) && (f[15] != aa[15]);
        e.cyc = t;
        return e;
    endfunction

    // Samples handshake/outputs just after the falling edge, then advances one cycle.
    task automatic step();
        #1;
        ir    = in_ready;
        ov    = out_valid;
        ix    = in_valid && in_ready;
        ox    = out_valid && out_ready;
        got_s = sum;
        got_c = cout;
        got_o = ovf;
        now   = cyc;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (sum !== 16'h0) begin errors++; $display("FAIL rst_sum got=%h exp=0000", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL rst_cout got=%b exp=0", cout); end
`ifdef PIPE_ADDER_OVF_EN
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf got=%b exp=0", ovf); end
`endif
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [15:0] ta [7] = '{16'h00FF, 16'hFFFF, 16'h0005, 16'h0007, 16'h7FFF, 16'h8000, 16'h1234};
        logic [15:0] tb [7] = '{16'h0001, 16'h0000, 16'h0007, 16'h0005, 16'h0001, 16'h0001, 16'h4321};
        logic        tc [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic        tu [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [15:0] ts [7] = '{16'h0100, 16'h0000, 16'hFFFE, 16'h0002, 16'h8000, 16'h7FFF, 16'h5556};
        logic        tk [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic        to [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        exp_t e;
        out_ready = 1'b1;
        for (int i = 0; i < 30 && (i < 7 || q.size() != 0); i++) begin
            in_valid = i < 7;
            if (i < 7) begin
                a = ta[i]; b = tb[i]; cin = tc[i]; sub = tu[i];
            end
            step();
            if (ix) begin
                e.s = ts[i]; e.c = tk[i]; e.o = to[i]; e.cyc = now;
                q.push_back(e);
            end
            if (ox) begin
                if (q.size() == 0) begin
                    checks++; errors++; $display("FAIL dir_spurious sum=%h", got_s);
                end else begin
                    e = q.pop_front();
                    checks++; if (got_s !== e.s) begin errors++; $display("FAIL dir_sum got=%h exp=%h", got_s, e.s); end
                    checks++; if (got_c !== e.c) begin errors++; $display("FAIL dir_cout got=%b exp=%b sum=%h", got_c, e.c, e.s); end
                    checks++; if (now - e.cyc != 4) begin errors++; $display("FAIL dir_latency got=%0d exp=4", now - e.cyc); end
`ifdef PIPE_ADDER_OVF_EN
                    checks++; if (got_o !== e.o) begin errors++; $display("FAIL dir_ovf got=%b exp=%b sum=%h", got_o, e.o, e.s); end
`endif
                end
            end
        end
        in_valid = 1'b0;
        checks++; if (q.size() != 0) begin errors++; $display("FAIL dir_drain pending=%0d exp=0", q.size()); q.delete(); end
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        int          sent = 0, recv = 0;
        bit          stall = 0;
        logic [15:0] hold_s = '0;
        logic        hold_c = 1'b0;
        for (int i = 0; i < 500 && recv < 20; i++) begin
            in_valid  = sent < 20;
            a         = 16'($urandom);
            b         = 16'($urandom);
            cin       = 1'($urandom);
            sub       = 1'($urandom);
            out_ready = 1'($urandom);
            step();
            if (stall) begin
                checks++; if (got_s !== hold_s || got_c !== hold_c) begin errors++; $display("FAIL b2b_stable got=%h/%b exp=%h/%b", got_s, got_c, hold_s, hold_c); end
            end
            if (q.size() == 4 && !out_ready) begin
                checks++; if (ir !== 1'b0) begin errors++; $display("FAIL b2b_full_ready got=%b exp=0", ir); end
            end
            stall  = ov && !out_ready;
            hold_s = got_s;
            hold_c = got_c;
            if (ox) begin
                if (q.size() == 0) begin
                    checks++; errors++; $display("FAIL b2b_spurious sum=%h", got_s);
                end else begin
                    e = q.pop_front();
                    recv++;
                    checks++; if (got_s !== e.s || got_c !== e.c) begin errors++; $display("FAIL b2b_result got=%h/%b exp=%h/%b", got_s, got_c, e.s, e.c); end
`ifdef PIPE_ADDER_OVF_EN
                    checks++; if (got_o !== e.o) begin errors++; $display("FAIL b2b_ovf got=%b exp=%b", got_o, e.o); end
`endif
                end
            end
            if (ix) begin
                q.push_back(model(a, b, cin, sub, now));
                sent++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++; if (recv != 20) begin errors++; $display("FAIL b2b_count got=%0d exp=20", recv); end
        q.delete();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   seen = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            a = 16'h1000 * 16'(i + 1); b = 16'h0101; cin = 1'b0; sub = 1'b0;
            step();
            if (ix) q.push_back(model(a, b, cin, sub, now));
        end
        checks++; if (q.size() != 4) begin errors++; $display("FAIL mid_fill got=%0d exp=4", q.size()); end
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_full_ready got=%b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_full_valid got=%b exp=1", out_valid); end
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got=%b exp=0", out_valid); end
        q.delete();
        @(posedge clk);
        @(negedge clk);
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (ox) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL mid_ghost got=%0d exp=0", seen); end
        in_valid = 1'b1; a = 16'h1234; b = 16'h0FFF; cin = 1'b0; sub = 1'b1;
        step();
        if (ix) q.push_back(model(a, b, cin, sub, now));
        in_valid = 1'b0;
        for (int i = 0; i < 10 && q.size() != 0; i++) begin
            step();
            if (ox) begin
                e = q.pop_front();
                checks++; if (got_s !== 16'h0235 || got_c !== 1'b1) begin errors++; $display("FAIL mid_result got=%h/%b exp=0235/1", got_s, got_c); end
                checks++; if (now - e.cyc != 4) begin errors++; $display("FAIL mid_latency got=%0d exp=4", now - e.cyc); end
            end
        end
        checks++; if (q.size() != 0) begin errors++; $display("FAIL mid_drain pending=%0d exp=0", q.size()); q.delete(); end
    endtask

    task automatic test_single_stage();
        #1;
        checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL s1_idle got=%b exp=0", out_valid8); end
        @(negedge clk);
        a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; sub8 = 1'b0; in_valid8 = 1'b1;
        #1;
        checks++; if (in_ready8 !== 1'b1) begin errors++; $display("FAIL s1_ready got=%b exp=1", in_ready8); end
        @(posedge clk);
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b1; sub8 = 1'b1;
        #1;
        checks++; if (out_valid8 !== 1'b1) begin errors++; $display("FAIL s1_valid got=%b exp=1", out_valid8); end
        checks++; if (sum8 !== 8'h00 || cout8 !== 1'b1) begin errors++; $display("FAIL s1_add got=%h/%b exp=00/1", sum8, cout8); end
`ifdef PIPE_ADDER_OVF_EN
        checks++; if (ovf8 !== 1'b1) begin errors++; $display("FAIL s1_ovf got=%b exp=1", ovf8); end
`endif
        @(posedge clk);
        @(negedge clk);
        in_valid8 = 1'b0;
        #1;
        checks++; if (sum8 !== 8'hF0 || cout8 !== 1'b0) begin errors++; $display("FAIL s1_sub got=%h/%b exp=F0/0", sum8, cout8); end
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL s1_empty got=%b exp=0", out_valid8); end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_single_stage();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_adder.md
Name: pipe_adder

Overview:
- Parametrised, pipelined WIDTH-bit adder/subtractor with valid/ready handshake on input and output.
- Operands are split into STAGES equal chunks. Each pipeline stage adds one chunk, LSB chunk first, and registers the carry into the next stage.
- Sits in datapath blocks (accumulators, address generators) where a single-cycle ripple chain would not meet timing.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages and chunks; CHUNK = WIDTH/STAGES. STAGES=1 gives a registered single-cycle adder.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts the beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; used only when sub=0.
- sub  in  1  0: a+b+cin; 1: a-b, computed as a+~b+1 (cin ignored).
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  result modulo 2^WIDTH.
- cout  out  1  carry out of the MSB. For sub=1: 1 means no borrow (a>=b, unsigned).

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: every stage valid bit = 0, out_valid=0, sum=0, cout=0. in_ready goes to 1 on the first cycle after reset release. Data registers need not be reset except the output stage.
- Transfer rules: input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
- Stage k (0..STAGES-1) holds:
  - valid bit;
  - partial sum bits [(k+1)*CHUNK-1:0];
  - running carry;
  - the remaining upper chunks of a and effective b.
- Effective b (b ^ {WIDTH{sub}}) and effective carry-in (sub ? 1 : cin) are formed at the input, before stage 0.
- Stage k adds chunk k of a, chunk k of effective b and the incoming carry. The new carry is registered alongside the data.
- Latency: exactly STAGES cycles from input transfer to out_valid, with no back-pressure. Throughput: one operation per cycle.
- Advance rule: stage k loads when stage k is empty or stage k itself advances this cycle. The last stage is drained by an output transfer. This gives a full-throughput stall pipeline with no bubbles inserted.
- in_ready = !valid[0] | advance[0]. It is combinational from out_ready through the chain; this path is accepted.
- Back-pressure: while out_ready=0 with a full pipeline, all stages hold and in_ready=0. Up to STAGES results may be in flight. None are lost, duplicated or reordered.
- Simultaneous input and output transfer on a full pipeline: every stage shifts, and occupancy is unchanged.
- sum/cout are stable while out_valid=1 and out_ready=0.
- Reset mid-operation clears all in-flight results immediately; no partial output appears afterwards.

Optional Feature:
- Macro: PIPE_ADDER_OVF_EN.
- Defined:
  - adds output port ovf (1 bit, reset 0), travelling with sum;
  - ovf = signed overflow: carry into MSB XOR carry out of MSB;
  - the stage holding the top chunk also registers the carry into bit WIDTH-1.
- Undefined: port absent, no extra logic.

Decomposition:
- Package pipe_adder_pkg:
  - function for the CHUNK width and a compile-time check that WIDTH % STAGES == 0;
  - localparam for the default width.
- Sub-module adder_chunk: combinational CHUNK-bit ripple adder built from full-adder cells, with inputs a, b, cin and outputs sum, cout, c_msb_in (carry into its top bit, for ovf). One instance per stage, via generate.

Test Plan:
- WIDTH=16, STAGES=4, out_ready=1; a=0x00FF, b=0x0001, cin=0, sub=0 -> exactly 4 cycles later out_valid=1, sum=0x0100, cout=0. Carry crosses the chunk 1/2 boundary.
- a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1. Carry ripples through all stages.
- sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0. Then a=7, b=5 -> sum=0x0002, cout=1. With PIPE_ADDER_OVF_EN: a=0x7FFF, b=0x0001, sub=0 -> ovf=1.
- Back-to-back stream of 20 random operands, with out_ready toggling pseudo-randomly (50%) -> scoreboard shows all 20 results in order and correct. in_ready=0 whenever the pipeline is full and out_ready=0.
- Fill the pipeline (4 beats, out_ready=0), assert rst for 1 cycle mid-stream -> out_valid=0 the same cycle, nothing emitted after release, next operand returns a correct result 4 cycles after its transfer.
- STAGES=1, WIDTH=8: a=0x80, b=0x80 -> sum=0x00, cout=1, latency 1 cycle.
